axi_slave_wr_ctrl: RTL and testbench



---
 rtl/axi_slave_wr_ctrl.sv | 121 ++++++++++++
 tb/tb_axi_slave_wr_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_wr_ctrl.sv
// axi_slave_wr_ctrl: AXI4 write-path slave that turns each burst into single-word memory writes.
// Optional AXI_WR_ERR_CNT_EN adds a saturating err_count of non-OKAY write responses.
module axi_slave_wr_ctrl #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int MEM_DEPTH  = 256,
    parameter int MEM_AW     = $clog2(MEM_DEPTH)
) (
    input  logic                  sig_clock,
    input  logic                  sig_reset,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [STRB_WIDTH-1:0] mem_wstrb
`ifdef AXI_WR_ERR_CNT_EN
    ,output logic [15:0]          err_count
`endif
);
    localparam int SHIFT = $clog2(STRB_WIDTH);
    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
    state_t state, state_nx;
    logic [ID_WIDTH-1:0] id_q;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [7:0] len_q, beat_cnt;
    logic [1:0] burst_q;
    logic aw_err, wl_err, dec_err;
    logic aw_hs, w_hs, last_beat, in_range;
    assign aw_hs     = awvalid & awready;
    assign w_hs      = wvalid & wready;
    assign last_beat = beat_cnt == len_q;
    assign in_range  = ptr < ADDR_WIDTH'(MEM_DEPTH);
    assign bid       = id_q;
    always_ff @(posedge sig_clock)
        if (!sig_reset) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        bresp    = 2'b00;
        case (state)
            IDLE: begin
                awready  = 1'b1;
                state_nx = awvalid ? DATA : IDLE;
            end
            DATA: begin
                wready   = 1'b1;
                state_nx = (wvalid && last_beat) ? RESP : DATA;
            end
            RESP: begin
                bvalid   = 1'b1;
                bresp    = dec_err ? 2'b11 : (aw_err | wl_err) ? 2'b10 : 2'b00;
                state_nx = bready ? IDLE : RESP;
            end
            default: state_nx = IDLE;
        endcase
    end
    // aw_err blocks memory writes; wl_err (wlast mismatch) only affects the response
    always_ff @(posedge sig_clock) begin
        if (!sig_reset) begin
            id_q      <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            ptr       <= '0;
            beat_cnt  <= '0;
            aw_err    <= 1'b0;
            wl_err    <= 1'b0;
            dec_err   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            mem_we <= 1'b0;
            if (aw_hs) begin
                id_q     <= awid;
                len_q    <= awlen;
                burst_q  <= awburst;
                ptr      <= awaddr >> SHIFT;
                beat_cnt <= '0;
                aw_err   <= awburst[1] | (awsize != 3'(SHIFT));
                wl_err   <= 1'b0;
                dec_err  <= 1'b0;
            end
            if (w_hs) begin
                mem_we    <= !aw_err && in_range;
                mem_addr  <= ptr[MEM_AW-1:0];
                mem_wdata <= wdata;
                mem_wstrb <= wstrb;
                beat_cnt  <= beat_cnt + 8'd1;
                if (!in_range) dec_err <= 1'b1;
                if (wlast != last_beat) wl_err <= 1'b1;
                if (burst_q == 2'b01) ptr <= ptr + ADDR_WIDTH'(1);
            end
        end
    end
`ifdef AXI_WR_ERR_CNT_EN
    always_ff @(posedge sig_clock)
        if (!sig_reset) err_count <= '0;
        else if (bvalid && bready && bresp != 2'b00 && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`endif
endmodule

// File: tb/tb_axi_slave_wr_ctrl.sv
// tb_axi_slave_wr_ctrl: scoreboard bench for axi_slave_wr_ctrl with directed and randomized bursts.
// Expectations are derived per burst from address/length/burst rules; a monitor pops them on DUT outputs.
module tb_axi_slave_wr_ctrl;
    logic sig_clock = 0, sig_reset = 0;
    logic [3:0] awid = 0;
    logic [31:0] awaddr = 0;
    logic [7:0] awlen = 0;
    logic [2:0] awsize = 0;
    logic [1:0] awburst = 0;
    logic awvalid = 0, awready;
    logic [31:0] wdata = 0;
    logic [3:0] wstrb = 0;
    logic wlast = 0, wvalid = 0, wready;
    logic [3:0] bid;
    logic [1:0] bresp;
    logic bvalid, bready = 0;
    logic mem_we;
    logic [7:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0] mem_wstrb;
`ifdef AXI_WR_ERR_CNT_EN
    logic [15:0] err_count;
    int exp_err = 0;
`endif
    int total = 0, bad = 0;

    typedef struct {logic [7:0] a; logic [31:0] d; logic [3:0] s;} mw_t;
    typedef struct {logic [3:0] id; logic [1:0] r;} b_t;
    mw_t mq[$];
    b_t bq[$];
    mw_t m;
    b_t b;

    axi_slave_wr_ctrl dut (
        .sig_clock(sig_clock), .sig_reset(sig_reset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
`ifdef AXI_WR_ERR_CNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 sig_clock = ~sig_clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    always @(negedge sig_clock) if (sig_reset) begin
`ifdef AXI_WR_ERR_CNT_EN
        check("err_count", err_count, exp_err);
`endif
        if (mem_we) begin
            if (mq.size() == 0) fail_now("unexpected mem_we");
            else begin
                m = mq.pop_front();
                check("mem_addr", mem_addr, m.a);
                check("mem_wdata", mem_wdata, m.d);
                check("mem_wstrb", mem_wstrb, m.s);
            end
        end
        if (bvalid) begin
            if (bq.size() == 0) fail_now("unexpected bvalid");
            else begin
                check("bid", bid, bq[0].id);
                check("bresp", bresp, bq[0].r);
                if (bready) begin
                    b = bq.pop_front();
`ifdef AXI_WR_ERR_CNT_EN
                    if (b.r != 2'b00 && exp_err != 16'hFFFF) exp_err++;
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge sig_clock);
        #1;
    endtask

    task automatic do_reset();
        sig_reset = 0;
        awvalid = 0;
        wvalid = 0;
        bready = 0;
        mq.delete();
        bq.delete();
`ifdef AXI_WR_ERR_CNT_EN
        exp_err = 0;
`endif
        tick();
        sig_reset = 1;
        check("rst_awready", awready, 1);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_mem_we", mem_we, 0);
    endtask

    // early: beat index carrying wlast (-1 = proper last beat); rst_at: reset after that beat (-1 = none)
    task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] bt, input int early, input int rst_at,
                            input int bdelay, input logic [31:0] dbase, input int strb, input bit gaps);
        logic aerr, werr, derr;
        logic [31:0] p;
        int to;
        aerr = bt[1] || size != 3'd2;
        werr = 0;
        derr = 0;
        awid = id;
        awaddr = addr;
        awlen = len;
        awsize = size;
        awburst = bt;
        awvalid = 1;
        to = 0;
        while (!awready && to < 20) begin tick(); to++; end
        if (to == 20) fail_now("aw_timeout");
        tick();
        awvalid = 0;
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            p = (addr >> 2) + ((bt == 2'b01) ? 32'(i) : 32'd0);
            wdata = dbase + 32'(i);
            wstrb = (strb < 0) ? 4'($urandom_range(1, 15)) : 4'(strb);
            wlast = (early >= 0) ? (i == early) : (i == int'(len));
            werr |= (wlast != (i == int'(len)));
            if (p >= 256) derr = 1;
            else if (!aerr) mq.push_back('{p[7:0], wdata, wstrb});
            wvalid = 1;
            to = 0;
            while (!wready && to < 20) begin tick(); to++; end
            if (to == 20) fail_now("w_timeout");
            if (i == int'(len)) bq.push_back('{id, derr ? 2'b11 : (aerr | werr) ? 2'b10 : 2'b00});
            tick();
            wvalid = 0;
            wlast = 0;
            if (rst_at == i) begin
                tick();
                do_reset();
                return;
            end
        end
        to = 0;
        while (!bvalid && to < 20) begin tick(); to++; end
        if (to == 20) fail_now("b_timeout");
        repeat (bdelay) tick();
        bready = 1;
        tick();
        bready = 0;
        check("b_done", bvalid, 0);
        check("aw_back", awready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        do_reset();
        repeat (5) tick();
        check("idle_awready", awready, 1);
        check("idle_wready", wready, 0);
        check("idle_bvalid", bvalid, 0);
        check("idle_mem_we", mem_we, 0);
        check("idle_bid", bid, 0);
        check("idle_bresp", bresp, 0);
        check("idle_mem_addr", mem_addr, 0);
        do_burst(4'd5, 32'h10, 8'd3, 3'd2, 2'b01, -1, -1, 0, 32'hA0, 15, 0);
        do_burst(4'd2, 32'h20, 8'd1, 3'd2, 2'b00, -1, -1, 3, 32'h55, 15, 0);
        do_burst(4'd3, 32'h3FC, 8'd1, 3'd2, 2'b01, -1, -1, 0, 32'h77, 15, 0);
        do_burst(4'd4, 32'h40, 8'd1, 3'd2, 2'b10, -1, -1, 1, 32'h88, 15, 0);
        do_burst(4'd6, 32'h50, 8'd2, 3'd2, 2'b01, 1, -1, 0, 32'h99, 15, 0);
        do_burst(4'd7, 32'h60, 8'd3, 3'd2, 2'b01, -1, 0, 0, 32'hB0, 15, 0);
        do_burst(4'd8, 32'h70, 8'd2, 3'd2, 2'b01, -1, -1, 0, 32'hC0, 15, 0);
        do_burst(4'd9, 32'h3FC, 8'd1, 3'd2, 2'b01, -1, -1, 0, 32'h11, 15, 0);
        do_burst(4'd1, 32'h40, 8'd0, 3'd2, 2'b11, -1, -1, 0, 32'h22, 15, 0);
        do_burst(4'd2, 32'h44, 8'd1, 3'd2, 2'b01, 0, -1, 0, 32'h33, 15, 0);
        tick();
`ifdef AXI_WR_ERR_CNT_EN
        check("err_count_3", err_count, 16'd3);
`endif
        for (int n = 0; n < 60; n++) begin
            logic [1:0] bt;
            int early;
            logic [7:0] len;
            bt = ($urandom_range(0, 9) < 7) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            len = 8'($urandom_range(0, 7));
            early = ($urandom_range(0, 9) == 0) ? $urandom_range(0, int'(len) + 1) : -1;
            do_burst(4'($urandom), 32'($urandom_range(0, 270)) * 4, len,
                     ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 3)) : 3'd2,
                     bt, early, -1, $urandom_range(0, 3), $urandom, -1, 1);
        end
        repeat (3) tick();
        check("mem_queue_empty", mq.size(), 0);
        check("b_queue_empty", bq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
